// File: rtl/ldtu_dec_pkg.sv
// Shared types, header constants and the word decode function for the LiTe-DTU receive decoder.
package ldtu_dec_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned SAMPLE_W = 13;
  localparam int unsigned BAS_W    = 6;
  localparam int unsigned NSLOT    = 5;
  localparam int unsigned SLOT_W   = 3;

  localparam logic [1:0]  HDR_BAS5  = 2'b01;
  localparam logic [1:0]  HDR_BASN  = 2'b10;
  localparam logic [5:0]  HDR_SIG2  = 6'b001010;
  localparam logic [5:0]  HDR_SIG1  = 6'b001011;
  localparam logic [12:0] SIG1_SYNC = 13'h0AAA;
  localparam logic [12:0] SIG1_HDR  = 13'h1E0F;

  localparam logic [1:0] FB_HDR    = 2'b11;
  localparam logic [1:0] FB_PLAIN  = 2'b11;
  localparam logic [1:0] FB_BC0_S0 = 2'b00;
  localparam logic [1:0] FB_BC0_S1 = 2'b01;
  localparam logic [1:0] FB_BAD    = 2'b10;

  // Slot index that never matches, used when a word carries no orbit marker.
  localparam logic [SLOT_W-1:0] SLOT_NONE = SLOT_W'(7);

  typedef enum logic {ST_IDLE, ST_EMIT} state_e;

  typedef struct packed {
    logic [SLOT_W-1:0]                k;
    logic [NSLOT-1:0][SAMPLE_W-1:0]   samples;
    logic                             bas;
    logic [SLOT_W-1:0]                bc0_slot;
    logic                             parity_bad;
    logic                             invalid;
  } dec_word_t;

  function automatic dec_word_t decode_word(input logic [WORD_W-1:0] w, input logic fb);
    dec_word_t d;
    d          = '0;
    d.bc0_slot = SLOT_NONE;
    if (fb) begin
      d.k          = SLOT_W'(2);
      d.samples[0] = w[12:0];
      d.samples[1] = w[25:13];
      d.parity_bad = (w[26] != ~^w[12:0]) || (w[27] != ~^w[25:13]);
      if (w[31:30] != FB_HDR) begin
        d.invalid = 1'b1;
      end else begin
        case (w[29:28])
          FB_PLAIN:  d.bc0_slot = SLOT_NONE;
          FB_BC0_S0: d.bc0_slot = '0;
          FB_BC0_S1: d.bc0_slot = SLOT_W'(1);
          FB_BAD:    d.invalid  = 1'b1;
        endcase
      end
    end else if (w[31:30] == HDR_BAS5 || w[31:30] == HDR_BASN) begin
      d.bas = 1'b1;
      for (int i = 0; i < NSLOT; i++) begin
        d.samples[i] = SAMPLE_W'(w[BAS_W*i +: BAS_W]);
      end
      if (w[31:30] == HDR_BAS5) d.k = SLOT_W'(5);
      else if (w[29:24] >= 6'd1 && w[29:24] <= 6'd4) d.k = w[26:24];
      else d.invalid = 1'b1;
    end else if (w[31:26] == HDR_SIG2) begin
      d.k          = SLOT_W'(2);
      d.samples[0] = w[12:0];
      d.samples[1] = w[25:13];
    end else if (w[31:26] == HDR_SIG1 && (w[25:13] == SIG1_SYNC || w[25:13] == SIG1_HDR)) begin
      d.k          = SLOT_W'(1);
      d.samples[0] = w[12:0];
      if (w[25:13] == SIG1_HDR) d.bc0_slot = '0;
    end else begin
      d.invalid = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/ldtu_dec_word_fifo.sv
// Synchronous word FIFO with flush; one extra pointer bit distinguishes full from empty.
module ldtu_dec_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign empty_c   = (wr_ptr_q == rd_ptr_q);
  assign full_c    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign rd_data_c = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ldtu_decoder.sv
// LiTe-DTU receive decoder: buffers 32-bit words and serialises them into one tagged 13-bit sample per clock.
module ldtu_decoder
  import ldtu_dec_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                fallback,
  input  logic                load_in,
  input  logic [WORD_W-1:0]   data_in,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                sample_bas,
  output logic                sample_bc0,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overflow
);

  state_e              state_q, state_d;
  dec_word_t           word_q, word_d, dec_c;
  logic [SLOT_W-1:0]   idx_q, idx_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                valid_q, valid_d, bas_q, bas_d, bc0_q, bc0_d;
  logic                parity_err_q, parity_err_d, frame_err_q, frame_err_d;
  logic                overflow_q, overflow_d, fallback_q, fallback_d;
  logic                mode_chg_c, last_slot_c;
  logic                fifo_push_c, fifo_pop_c, fifo_full_c, fifo_empty_c;
  logic [WORD_W-1:0]   fifo_rdata_c;

  ldtu_dec_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .flush     (mode_chg_c),
    .push      (fifo_push_c),
    .pop       (fifo_pop_c),
    .wr_data   (data_in),
    .rd_data_c (fifo_rdata_c),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c)
  );

  assign fallback_d  = fallback;
  assign mode_chg_c  = (fallback != fallback_q);
  assign dec_c       = decode_word(fifo_rdata_c, fallback_q);
  assign last_slot_c = (idx_q == word_q.k - SLOT_W'(1)) || word_q.invalid;

  // Next-state and output logic; slot 0 of a word fetched in IDLE goes out on the pop edge.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    idx_d        = idx_q;
    sample_d     = sample_q;
    bas_d        = bas_q;
    bc0_d        = bc0_q;
    valid_d      = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    fifo_pop_c   = 1'b0;
    if (mode_chg_c) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty_c) begin
            fifo_pop_c = 1'b1;
            if (dec_c.invalid) begin
              frame_err_d = 1'b1;
            end else begin
              valid_d      = 1'b1;
              sample_d     = dec_c.samples[0];
              bas_d        = dec_c.bas;
              bc0_d        = (dec_c.bc0_slot == '0);
              parity_err_d = dec_c.parity_bad;
              word_d       = dec_c;
              idx_d        = SLOT_W'(1);
              if (dec_c.k != SLOT_W'(1)) state_d = ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          valid_d      = 1'b1;
          sample_d     = word_q.samples[idx_q];
          bas_d        = word_q.bas;
          bc0_d        = (word_q.bc0_slot == idx_q);
          parity_err_d = word_q.parity_bad && (idx_q == '0);
          idx_d        = idx_q + SLOT_W'(1);
          if (last_slot_c) begin
            state_d = ST_IDLE;
            // Fetch the next word now so its first sample follows without a bubble.
            if (!fifo_empty_c) begin
              fifo_pop_c = 1'b1;
              if (dec_c.invalid) begin
                frame_err_d = 1'b1;
              end else begin
                word_d  = dec_c;
                idx_d   = '0;
                state_d = ST_EMIT;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    fifo_push_c = load_in && !mode_chg_c && (!fifo_full_c || fifo_pop_c);
    overflow_d  = overflow_q || (load_in && !mode_chg_c && fifo_full_c && !fifo_pop_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q      <= ST_IDLE;
      word_q       <= '0;
      idx_q        <= '0;
      sample_q     <= '0;
      valid_q      <= 1'b0;
      bas_q        <= 1'b0;
      bc0_q        <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      fallback_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      sample_q     <= sample_d;
      valid_q      <= valid_d;
      bas_q        <= bas_d;
      bc0_q        <= bc0_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
      fallback_q   <= fallback_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign sample_bas   = bas_q;
  assign sample_bc0   = bc0_q;
  assign parity_err   = parity_err_q;
  assign frame_err    = frame_err_q;
  assign overflow     = overflow_q;

endmodule
